// File: rtl/fifo_window_reader.sv
// rtl/fifo_window_reader.sv - sliding-window reader between two single-element FIFOs
// Pops samples upstream, emits KERNEL_WIDTH-deep windows per frame downstream.
module fifo_window_reader #(
  parameter int WORD_SIZE    = 16,
  parameter int KERNEL_WIDTH = 3,
  parameter int INPUT_LENGTH = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               full_i,
  input  logic [WORD_SIZE-1:0]               data_i,
  output logic                               ren_o,
  input  logic                               empty_i,
  output logic                               wen_o,
  output logic [WORD_SIZE*KERNEL_WIDTH-1:0]  data_o,
  output logic                               last_o
);

  localparam int IDX_W  = $clog2(INPUT_LENGTH);
  localparam int FILL_W = $clog2(KERNEL_WIDTH + 1);

  typedef enum logic {eFILL, eSTREAM} state_t;

  state_t                                   state_q, state_d;
  logic [KERNEL_WIDTH-1:0][WORD_SIZE-1:0]   win_q, win_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [FILL_W-1:0]                        fill_q, fill_d;
  logic                                     wen_q, wen_d;
  logic                                     last_q, last_d;
  logic [WORD_SIZE*KERNEL_WIDTH-1:0]        data_q, data_d;

  logic pop;
  logic accept;
  logic frame_end;
  logic emit;

  // A pending window only blocks the pop while the downstream is still full.
  assign ren_o  = full_i & (~wen_q | empty_i) & ~reset_i;
  assign pop    = ren_o;
  assign accept = wen_q & empty_i;

  assign frame_end = (idx_q == IDX_W'(INPUT_LENGTH - 1));
  assign emit      = (state_q == eSTREAM) || (fill_q == FILL_W'(KERNEL_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    wen_d   = wen_q;
    last_d  = last_q;
    data_d  = data_q;

    if (accept) begin
      wen_d  = 1'b0;
      last_d = 1'b0;
    end

    if (pop) begin
      win_d = {win_q[KERNEL_WIDTH-2:0], data_i};

      if (emit) begin
        wen_d  = 1'b1;
        data_d = win_d;
        last_d = frame_end;
      end

      if (frame_end) begin
        idx_d   = '0;
        fill_d  = '0;
        state_d = eFILL;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        if (state_q == eFILL) begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(KERNEL_WIDTH - 1)) begin
            state_d = eSTREAM;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eFILL;
      win_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      wen_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      wen_q   <= wen_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign wen_o  = wen_q;
  assign last_o = last_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_fifo_window_reader.sv
// tb/tb_fifo_window_reader.sv - scoreboard bench for fifo_window_reader
// Upstream is a sample queue, downstream acceptance is driven by empty_i.
module tb_fifo_window_reader;

  localparam int W  = 16;
  localparam int K  = 3;
  localparam int L  = 8;
  localparam int WK = W * K;

  typedef struct {
    logic [WK-1:0] data;
    logic          last;
  } win_t;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          full_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ren_o;
  logic          empty_i = 1'b0;
  logic          wen_o;
  logic [WK-1:0] data_o;
  logic          last_o;

  int checks = 0;
  int errors = 0;
  int last_cnt = 0;

  logic [W-1:0] src[$];
  win_t         exp_q[$];

  logic          s_wen, s_ren, s_last;
  logic [WK-1:0] s_data;

  fifo_window_reader #(.WORD_SIZE(W), .KERNEL_WIDTH(K), .INPUT_LENGTH(L)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .full_i  (full_i),
    .data_i  (data_i),
    .ren_o   (ren_o),
    .empty_i (empty_i),
    .wen_o   (wen_o),
    .data_o  (data_o),
    .last_o  (last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Slot i holds sample (newest - i); slot 0 is the newest.
  function automatic logic [WK-1:0] mkwin(input int newest);
    logic [WK-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++) w[W*i +: W] = W'(newest - i);
    return w;
  endfunction

  task automatic push_frame(input int base);
    win_t e;
    for (int i = 0; i < L; i++) src.push_back(W'(base + i));
    for (int j = 0; j <= L - K; j++) begin
      e.data = mkwin(base + j + K - 1);
      e.last = (j == L - K);
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle(input bit fe, input bit ee);
    win_t e;
    @(negedge clk);
    full_i  = fe && (src.size() > 0);
    data_i  = full_i ? src[0] : '0;
    empty_i = ee;
    #1;
    s_wen  = wen_o;
    s_ren  = ren_o;
    s_data = data_o;
    s_last = last_o;
    check("ren_rule", 64'(s_ren), 64'(full_i & (~s_wen | empty_i)));
    if (s_wen && empty_i) begin
      check("window_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("window_data", 64'(s_data), 64'(e.data));
        check("window_last", 64'(s_last), 64'(e.last));
        if (s_last) last_cnt++;
      end
    end
    @(posedge clk);
    if (s_ren) void'(src.pop_front());
  endtask

  // mode 0: always ready, 1: upstream toggles, 2: random stalls both sides
  task automatic drain(input int mode);
    int n;
    n = 0;
    while ((src.size() > 0 || exp_q.size() > 0) && n < 20000) begin
      case (mode)
        0:       cycle(1'b1, 1'b1);
        1:       cycle(n % 2 == 0, 1'b1);
        default: cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      endcase
      n++;
    end
    check("drain_done", 64'(src.size() + exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    full_i  = 1'b1;
    empty_i = 1'b0;
    #1;
    check("reset_ren", 64'(ren_o), 64'(0));
    @(posedge clk);
    #1;
    check("reset_wen", 64'(wen_o), 64'(0));
    check("reset_data", 64'(data_o), 64'(0));
    check("reset_last", 64'(last_o), 64'(0));
    @(negedge clk);
    reset_i = 1'b0;
    full_i  = 1'b0;
  endtask

  initial begin
    win_t e;
    do_reset();

    // Tests 1+2: two back-to-back frames, full rate; two-cycle refill gap between them.
    push_frame(1);
    push_frame(9);
    for (int c = 0; c < 17; c++) begin
      cycle(1'b1, 1'b1);
      check("wen_timing", 64'(s_wen), 64'((c >= 3 && c <= 8) || (c >= 11 && c <= 16)));
    end
    check("frames_drained", 64'(exp_q.size()), 64'(0));

    // Test 3: backpressure while {2,3,4} is pending.
    push_frame(1);
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b0);
      check("bp_wen", 64'(s_wen), 64'(1));
      check("bp_data", 64'(s_data), 64'(mkwin(4)));
      check("bp_ren", 64'(s_ren), 64'(0));
    end
    drain(0);

    // Test 4: upstream gaps.
    push_frame(1);
    drain(1);

    // Test 5: reset after sample 5; the pending {3,4,5} is discarded.
    for (int i = 1; i <= 5; i++) src.push_back(W'(i));
    for (int n = 3; n <= 4; n++) begin
      e.data = mkwin(n);
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    drain(0);
    #1;
    check("pre_reset_wen", 64'(wen_o), 64'(1));
    check("pre_reset_data", 64'(data_o), 64'(mkwin(5)));
    do_reset();
    push_frame(21);
    check("post_reset_first", 64'(exp_q[0].data), 64'(mkwin(23)));
    drain(0);

    // Test 6: 100 frames with random stalls on both sides.
    last_cnt = 0;
    for (int f = 0; f < 100; f++) push_frame(100 + f * L);
    drain(2);
    check("last_count", 64'(last_cnt), 64'(100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
